instr_fetch_unit: RTL and testbench

- Producer side of the instruction queue: generates PCs, issues word reads to instruction memory, and pushes returned instructions into the queue via instr_in/is_enqueue.
- Honours queue_full backpressure. Branch redirects flush in-flight fetches.
- Sits between the instruction memory port and the instruction queue, feeding decode.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_buffer.sv | 82 ++++++++
 rtl/instr_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
//   fetch_state_e : controller states
//   fetch_entry_t : one queued instruction word with its fetch PC
//   PC_STEP       : byte increment between sequential fetches
//   CNT_W         : width of occupancy counters (covers depths up to 8)
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;
    localparam int          CNT_W   = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and instruction queue.
//   mem_req_valid/mem_req_ready/mem_addr : read request channel
//   mem_resp_valid/mem_resp_data         : in-order read response channel
//   instr_in/is_enqueue/enq_pc           : push side of the instruction queue
//   queue_full                           : queue backpressure
// master = fetch unit side, slave = memory/queue side.
interface instr_fetch_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        queue_full;
    logic [31:0] instr_in;
    logic        is_enqueue;
    logic [31:0] enq_pc;

    modport master (
        output mem_req_valid, mem_addr, instr_in, is_enqueue, enq_pc,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, queue_full
    );

    modport slave (
        input  mem_req_valid, mem_addr, instr_in, is_enqueue, enq_pc,
        output mem_req_ready, mem_resp_valid, mem_resp_data, queue_full
    );
endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch_entry_t with a flush that empties it in one cycle.
//   clk, rst : clock, synchronous active-high reset
//   push/wdata, pop/rdata : write and read sides; rdata is the current head
//   flush    : discard all entries (wins over push/pop)
//   count, empty : occupancy
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: generates sequential PCs, issues word reads to
// instruction memory and pushes returned words into the instruction queue.
//   clk, rst      : clock, synchronous active-high reset
//   fetch_en      : allows new requests (in-flight ones still complete)
//   branch_valid  : redirect; branch_target gives the new PC (low bits dropped)
//   busy          : requests in flight or words waiting to be enqueued
//   bus (master)  : memory request/response and queue push signals
//
// state | meaning
// IDLE  | out of reset, waiting for the first fetch_en
// FETCH | issuing requests, collecting responses, enqueueing
// FLUSH | redirect pending; dropping stale responses until none are in flight
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    input  logic                       branch_valid,
    input  logic [31:0]                branch_target,
    output logic                       busy,
    instr_fetch_unit_if.master         bus
);
    localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [31:0]    PC_INIT    = RESET_PC & ~32'h3;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    logic             req_valid, accept, resp, credit_ok, enq;
    logic [31:0]      branch_pc;
    logic             tag_pop, buf_push;
    fetch_entry_t     tag_wdata, tag_rdata, buf_wdata, buf_rdata;
    logic [CNT_W-1:0] tag_count, buf_count;
    logic             tag_empty, buf_empty;

    fetch_buffer #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (tag_pop),
        .flush (branch_valid),
        .wdata (tag_wdata),
        .rdata (tag_rdata),
        .count (tag_count),
        .empty (tag_empty)
    );

    fetch_buffer #(.DEPTH(MAX_OUTSTANDING)) u_resp_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (enq),
        .flush (branch_valid),
        .wdata (buf_wdata),
        .rdata (buf_rdata),
        .count (buf_count),
        .empty (buf_empty)
    );

    always_comb begin
        branch_pc = branch_target & ~32'h3;
        // Credits cover both in-flight requests and words parked in the buffer,
        // so a response always has a buffer slot waiting for it.
        credit_ok = ({1'b0, outstanding_q} + {1'b0, buf_count}) < CREDIT_LIM;
        req_valid = (state_q == FETCH) && fetch_en && !branch_valid && credit_ok;
        accept    = req_valid && bus.mem_req_ready;
        resp      = bus.mem_resp_valid && (outstanding_q != '0);

        tag_wdata       = '0;
        tag_wdata.pc    = pc_q;
        // Responses only survive in FETCH without a redirect this cycle.
        tag_pop         = resp && !tag_empty && (state_q == FETCH) && !branch_valid;
        buf_push        = tag_pop;
        buf_wdata       = tag_rdata;
        buf_wdata.instr = bus.mem_resp_data;

        enq = !buf_empty && !bus.queue_full && (state_q != FLUSH) && !branch_valid;
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        outstanding_d = outstanding_q;

        if (accept && !resp) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept && resp) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (branch_valid) pc_d = branch_pc;
                if (fetch_en)     state_d = FETCH;
            end
            FETCH: begin
                if (accept) pc_d = pc_q + PC_STEP;
                if (branch_valid) begin
                    if (outstanding_d != '0) begin
                        state_d  = FLUSH;
                        target_d = branch_pc;
                    end else begin
                        pc_d = branch_pc;
                    end
                end
            end
            FLUSH: begin
                if (branch_valid) target_d = branch_pc;
                if (outstanding_d == '0) begin
                    state_d = FETCH;
                    pc_d    = branch_valid ? branch_pc : target_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= PC_INIT;
            target_q      <= PC_INIT;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_addr      = pc_q;
    assign bus.is_enqueue    = enq;
    assign bus.instr_in      = buf_empty ? '0 : buf_rdata.instr;
    assign bus.enq_pc        = buf_empty ? '0 : buf_rdata.pc;
    // The tag FIFO never holds more than outstanding_q, so it adds nothing here
    // in practice; it is folded in so any tracked request keeps the unit busy.
    assign busy = (outstanding_q != '0) || !buf_empty || (tag_count != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        rst, fetch_en, branch_valid, busy;
    logic [31:0] branch_target;
    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .busy          (busy),
        .bus           (bus)
    );

    // wrap DUT (RESET_PC near the top of the address space)
    logic        w_rst, w_fe, w_br, w_busy;
    logic [31:0] w_tgt;
    instr_fetch_unit_if w_bus();

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MAX_OUTSTANDING(2)) u_wrap (
        .clk           (clk),
        .rst           (w_rst),
        .fetch_en      (w_fe),
        .branch_valid  (w_br),
        .branch_target (w_tgt),
        .busy          (w_busy),
        .bus           (w_bus)
    );

    typedef struct {
        logic        rst, fe, br;
        logic [31:0] tgt;
        logic        qf, ren;
        logic        req;
        logic [31:0] addr;
        logic        enq, cd;
        logic [31:0] instr, pc;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t  tbl[$];
    pend_t pend[$];
    int    cyc;
    int    n_vec = 0;
    int    n_err = 0;

    function automatic vec_t mk(input int r, fe, br, input logic [31:0] tgt,
                                input int qf, ren, req, input logic [31:0] addr,
                                input int enq, cd, input logic [31:0] instr, pc,
                                input int bsy);
        vec_t v;
        v.rst = (r != 0);   v.fe = (fe != 0);   v.br = (br != 0);   v.tgt = tgt;
        v.qf = (qf != 0);   v.ren = (ren != 0); v.req = (req != 0); v.addr = addr;
        v.enq = (enq != 0); v.cd = (cd != 0);   v.instr = instr;    v.pc = pc;
        v.busy = (bsy != 0);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        pend_t p;
        rst = v.rst; fetch_en = v.fe; branch_valid = v.br; branch_target = v.tgt;
        bus.queue_full = v.qf; bus.mem_req_ready = 1'b1;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        if (v.rst) begin
            pend.delete();
        end else if (v.ren && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = pend[0].addr + 32'h100;
            pend.delete(0);
        end
        #1;
        if (!v.rst) begin
            n_vec++;
            check("mem_req_valid", idx, {31'b0, bus.mem_req_valid}, {31'b0, v.req});
            check("mem_addr", idx, bus.mem_addr, v.addr);
            check("is_enqueue", idx, {31'b0, bus.is_enqueue}, {31'b0, v.enq});
            check("busy", idx, {31'b0, busy}, {31'b0, v.busy});
            if (v.cd) begin
                check("instr_in", idx, bus.instr_in, v.instr);
                check("enq_pc", idx, bus.enq_pc, v.pc);
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                p.addr = bus.mem_addr;
                p.due  = cyc + 1;
                pend.push_back(p);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wdrive(input logic fe, input logic rv, input logic [31:0] rd);
        w_fe = fe; w_bus.mem_resp_valid = rv; w_bus.mem_resp_data = rd;
        #1;
        n_vec++;
    endtask

    task automatic wclk();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // rst, fe, br, tgt, qf, ren | req, addr, enq, cd, instr, pc, busy
        tbl.push_back(mk(0,0,0,0,0,1, 0,32'h0,   0,1,32'h0,  32'h0, 0));  // reset values
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h0,   0,0,0,0, 0));            // IDLE -> FETCH
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h0,   0,0,0,0, 0));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h4,   0,0,0,0, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h8,   1,1,32'h100,32'h0, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h8,   1,1,32'h104,32'h4, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'hC,   0,0,0,0, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h10,  1,1,32'h108,32'h8, 1));
        // queue full for 10 cycles: head held, credits run out
        tbl.push_back(mk(0,1,0,0,1,1, 1,32'h10,  0,1,32'h10C,32'hC, 1));
        tbl.push_back(mk(0,1,0,0,1,1, 0,32'h14,  0,1,32'h10C,32'hC, 1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,1,0,0,1,1, 0,32'h14, 0,1,32'h10C,32'hC, 1));
        // release: both buffered words drain in order
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h14,  1,1,32'h10C,32'hC, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h14,  1,1,32'h110,32'h10, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h18,  0,0,0,0, 1));
        // hold responses to build up two outstanding, then redirect
        tbl.push_back(mk(0,1,0,0,0,0, 0,32'h1C,  1,1,32'h114,32'h14, 1));
        tbl.push_back(mk(0,1,0,0,0,0, 1,32'h1C,  0,0,0,0, 1));
        tbl.push_back(mk(0,1,1,32'h2002,0,0, 0,32'h20, 0,0,0,0, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h20,  0,0,0,0, 1));            // FLUSH, drop
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h20,  0,0,0,0, 1));            // FLUSH, drop last
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h2000,0,0,0,0, 0));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h2004,0,0,0,0, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h2008,1,1,32'h2100,32'h2000, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h2008,1,1,32'h2104,32'h2004, 1));
        // redirect with same-cycle last response: no FLUSH, response dropped
        tbl.push_back(mk(0,1,1,32'h3000,0,1, 0,32'h200C,0,0,0,0, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h3000,0,0,0,0, 0));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h3004,0,0,0,0, 1));
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h3008,1,1,32'h3100,32'h3000, 1));
        tbl.push_back(mk(0,1,0,0,1,0, 1,32'h3008,0,1,32'h3104,32'h3004, 1));
        // reset with one in flight and one buffered
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0,0,0, 0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,32'h0,   0,1,32'h0,  32'h0, 0));
        tbl.push_back(mk(0,1,0,0,0,1, 0,32'h0,   0,0,0,0, 0));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h0,   0,0,0,0, 0));
        tbl.push_back(mk(0,1,0,0,0,1, 1,32'h4,   0,0,0,0, 1));

        // initial reset of both DUTs
        cyc = 0;
        rst = 1'b1; fetch_en = 1'b0; branch_valid = 1'b0; branch_target = '0;
        bus.queue_full = 1'b0; bus.mem_req_ready = 1'b1;
        bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
        w_rst = 1'b1; w_fe = 1'b0; w_br = 1'b0; w_tgt = '0;
        w_bus.queue_full = 1'b0; w_bus.mem_req_ready = 1'b1;
        w_bus.mem_resp_valid = 1'b0; w_bus.mem_resp_data = '0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // PC wrap on the second instance; also fetch_en dropping in FETCH
        w_rst = 1'b0;
        wdrive(1'b1, 1'b0, '0);
        check("wrap_req", 100, {31'b0, w_bus.mem_req_valid}, 32'd0);
        check("wrap_addr", 100, w_bus.mem_addr, 32'hFFFF_FFF8);
        wclk();
        wdrive(1'b1, 1'b0, '0);
        check("wrap_req", 101, {31'b0, w_bus.mem_req_valid}, 32'd1);
        check("wrap_addr", 101, w_bus.mem_addr, 32'hFFFF_FFF8);
        wclk();
        wdrive(1'b1, 1'b0, '0);
        check("wrap_req", 102, {31'b0, w_bus.mem_req_valid}, 32'd1);
        check("wrap_addr", 102, w_bus.mem_addr, 32'hFFFF_FFFC);
        wclk();
        wdrive(1'b1, 1'b0, '0);
        check("wrap_req", 103, {31'b0, w_bus.mem_req_valid}, 32'd0);
        check("wrap_addr", 103, w_bus.mem_addr, 32'h0000_0000);
        wclk();
        wdrive(1'b1, 1'b1, 32'hAAAA_0000);
        check("wrap_req", 104, {31'b0, w_bus.mem_req_valid}, 32'd0);
        check("wrap_enq", 104, {31'b0, w_bus.is_enqueue}, 32'd0);
        check("wrap_busy", 104, {31'b0, w_busy}, 32'd1);
        wclk();
        wdrive(1'b1, 1'b0, '0);
        check("wrap_enq", 105, {31'b0, w_bus.is_enqueue}, 32'd1);
        check("wrap_instr", 105, w_bus.instr_in, 32'hAAAA_0000);
        check("wrap_pc", 105, w_bus.enq_pc, 32'hFFFF_FFF8);
        wclk();
        wdrive(1'b0, 1'b0, '0);
        check("wrap_fe_off_req", 106, {31'b0, w_bus.mem_req_valid}, 32'd0);
        check("wrap_busy", 106, {31'b0, w_busy}, 32'd1);
        wclk();
        wdrive(1'b1, 1'b0, '0);
        check("wrap_req", 107, {31'b0, w_bus.mem_req_valid}, 32'd1);
        check("wrap_addr", 107, w_bus.mem_addr, 32'h0000_0000);
        wclk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
